// File: rtl/ssm_output_fp16.sv
// SSM output stage: y[b][h][p] = D[h]*x[b][h][p] + sum_n h[b][h][p][n]*C[b][n], FP16,
// using one pipelined multiplier and one pipelined adder with a fixed serial sum order.

package ssm_output_fp16_pkg;
  // Round-to-nearest-even packing; subnormal results flush to signed zero.
  function automatic logic [15:0] fp16_pack(input logic s, input logic signed [7:0] e,
                                            input logic [10:0] m, input logic g, input logic st);
    logic [11:0]        mr;
    logic signed [7:0]  ex;
    mr = {1'b0, m} + {11'b0, g & (st | m[0])};
    ex = e;
    if (mr[11]) begin
      mr = mr >> 1;
      ex = ex + 8'sd1;
    end
    if (ex >= 8'sd31) return {s, 15'h7C00};
    if (ex <= 8'sd0)  return {s, 15'h0000};
    return {s, ex[4:0], mr[9:0]};
  endfunction

  function automatic logic fp16_nan(input logic [15:0] a);
    return (a[14:10] == 5'h1F) && (a[9:0] != '0);
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic              s;
    logic [21:0]       prod;
    logic signed [7:0] e;
    s = a[15] ^ b[15];
    if (fp16_nan(a) || fp16_nan(b)) return 16'h7E00;
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F)
      return (a[14:10] == '0 || b[14:10] == '0) ? 16'h7E00 : {s, 15'h7C00};
    if (a[14:10] == '0 || b[14:10] == '0) return {s, 15'h0000};
    prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15;
    if (prod[21]) return fp16_pack(s, e + 8'sd1, prod[21:11], prod[10], |prod[9:0]);
    return fp16_pack(s, e, prod[20:10], prod[9], |prod[8:0]);
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]       x, y;
    logic [4:0]        d;
    logic [24:0]       mx, my, sum, n;
    logic signed [7:0] lead, e;
    if (fp16_nan(a) || fp16_nan(b)) return 16'h7E00;
    if (a[14:10] == 5'h1F && b[14:10] == 5'h1F) return (a[15] != b[15]) ? 16'h7E00 : a;
    if (a[14:10] == 5'h1F) return a;
    if (b[14:10] == 5'h1F) return b;
    if (a[14:10] == '0 && b[14:10] == '0) return {a[15] & b[15], 15'h0000};
    if (a[14:10] == '0) return b;
    if (b[14:10] == '0) return a;
    if (a[14:0] >= b[14:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = x[14:10] - y[14:10];
    mx = {2'b01, x[9:0], 13'b0};
    // 13 spare bits keep alignment exact up to d=13; beyond that y is pure sticky.
    my = (d > 5'd13) ? 25'd1 : ({2'b01, y[9:0], 13'b0} >> d);
    sum = (x[15] == y[15]) ? mx + my : mx - my;
    if (sum == '0) return 16'h0000;
    lead = '0;
    for (int unsigned i = 0; i < 25; i++) if (sum[i]) lead = 8'(i);
    n = sum << (5'd24 - lead[4:0]);
    e = $signed({3'b0, x[14:10]}) + lead - 8'sd23;
    return fp16_pack(x[15], e, n[24:14], n[13], |n[12:0]);
  endfunction
endpackage

module fp16_mult_wrapper #(parameter int LAT = 6) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_valid,
  output logic [15:0] o_res
);
  logic [LAT-1:0] r_vld;
  logic [15:0]    r_res [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) r_res[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_res[0] <= ssm_output_fp16_pkg::fp16_mul(i_a, i_b);
      for (int unsigned i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_res[i] <= r_res[i-1];
      end
    end
  end
  assign o_valid = r_vld[LAT-1];
  assign o_res   = r_res[LAT-1];
endmodule

module fp16_add_wrapper #(parameter int LAT = 11) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_valid,
  output logic [15:0] o_res
);
  logic [LAT-1:0] r_vld;
  logic [15:0]    r_res [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) r_res[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_res[0] <= ssm_output_fp16_pkg::fp16_add(i_a, i_b);
      for (int unsigned i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_res[i] <= r_res[i-1];
      end
    end
  end
  assign o_valid = r_vld[LAT-1];
  assign o_res   = r_res[LAT-1];
endmodule

module ssm_output_fp16 #(
  parameter int B = 1, parameter int H = 4, parameter int P = 4, parameter int N = 4,
  parameter int DW = 16, parameter int M_LAT = 6, parameter int A_LAT = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [B*H*P*N*DW-1:0] h_flat,
  input  logic [B*N*DW-1:0]     C_flat,
  input  logic [H*DW-1:0]       D_flat,
  input  logic [B*H*P*DW-1:0]   x_flat,
  output logic [B*H*P*DW-1:0]   y_flat,
  output logic                  busy,
  output logic                  done
);
  localparam int KW = $clog2(N + 2);
  localparam int BW = $clog2(B + 1);
  localparam int HW = $clog2(H + 1);
  localparam int PW = $clog2(P + 1);

  typedef enum logic [2:0] {IDLE, MUL, ACC, WB, DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [BW-1:0]       r_b;
  logic [HW-1:0]       r_h;
  logic [PW-1:0]       r_p;
  logic [KW-1:0]       r_k, r_mcnt, r_acnt;
  logic [DW-1:0]       r_buf [N+1];
  logic [DW-1:0]       r_acc, r_add_a, r_add_b;
  logic                r_add_vld;
  logic [B*H*P*DW-1:0] r_y;
  logic [31:0]         w_e, w_n;
  logic                w_mul_vld, w_mul_ov, w_add_ov, w_last, w_run;
  logic [DW-1:0]       w_mul_a, w_mul_b, w_mul_res, w_add_res;

  fp16_mult_wrapper #(.LAT(M_LAT)) u_mul (
    .clk(clk), .rst_n(rst_n), .i_valid(w_mul_vld), .i_a(w_mul_a), .i_b(w_mul_b),
    .o_valid(w_mul_ov), .o_res(w_mul_res));
  fp16_add_wrapper #(.LAT(A_LAT)) u_add (
    .clk(clk), .rst_n(rst_n), .i_valid(r_add_vld), .i_a(r_add_a), .i_b(r_add_b),
    .o_valid(w_add_ov), .o_res(w_add_res));

  assign w_last = (r_b == BW'(B-1)) && (r_h == HW'(H-1)) && (r_p == PW'(P-1));
  assign w_run  = (r_state == MUL) || (r_state == ACC);

  always_comb begin
    w_state_nxt = r_state;
    w_mul_vld   = 1'b0;
    w_e         = 32'((int'(r_b) * H + int'(r_h)) * P + int'(r_p));
    w_n         = 32'(int'(r_k) - 1);
    w_mul_a     = D_flat[int'(r_h)*DW +: DW];
    w_mul_b     = x_flat[w_e*DW +: DW];
    if (r_k != '0) begin
      w_mul_a = h_flat[(w_e*N + w_n)*DW +: DW];
      w_mul_b = C_flat[(int'(r_b)*N + w_n)*DW +: DW];
    end
    case (r_state)
      IDLE: if (start) w_state_nxt = MUL;
      MUL: begin
        w_mul_vld = 1'b1;
        if (r_k == KW'(N)) w_state_nxt = ACC;
      end
      ACC:  if (w_add_ov && r_acnt == KW'(N-1)) w_state_nxt = WB;
      WB:   w_state_nxt = w_last ? DONE : MUL;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      {r_b, r_h, r_p, r_k, r_mcnt, r_acnt} <= '0;
      for (int unsigned i = 0; i <= N; i++) r_buf[i] <= '0;
      {r_acc, r_add_a, r_add_b} <= '0;
      r_add_vld <= 1'b0;
      r_y       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_add_vld <= 1'b0;
      if (r_state == IDLE && start) begin
        {r_b, r_h, r_p, r_k, r_mcnt, r_acnt} <= '0;
      end
      if (r_state == MUL && r_k != KW'(N)) r_k <= r_k + 1'b1;
      if (r_state == WB) begin
        r_y[w_e*DW +: DW] <= r_acc;
        {r_k, r_mcnt, r_acnt} <= '0;
        if (r_p == PW'(P-1)) begin
          r_p <= '0;
          if (r_h == HW'(H-1)) begin
            r_h <= '0;
            r_b <= r_b + 1'b1;
          end else r_h <= r_h + 1'b1;
        end else r_p <= r_p + 1'b1;
      end
      // The first add takes prod1 straight off the multiplier so it issues the cycle after capture.
      if (w_run && w_mul_ov) begin
        r_buf[r_mcnt] <= w_mul_res;
        r_mcnt        <= r_mcnt + 1'b1;
        if (r_mcnt == KW'(1)) begin
          r_add_a   <= r_buf[0];
          r_add_b   <= w_mul_res;
          r_add_vld <= 1'b1;
        end
      end
      if (w_run && w_add_ov) begin
        r_acc  <= w_add_res;
        r_acnt <= r_acnt + 1'b1;
        if (r_acnt + KW'(2) <= KW'(N)) begin
          r_add_a   <= w_add_res;
          r_add_b   <= r_buf[r_acnt + KW'(2)];
          r_add_vld <= 1'b1;
        end
      end
    end
  end

  assign y_flat = r_y;
  assign busy   = w_run || (r_state == WB);
  assign done   = (r_state == DONE);
endmodule

// File: doc/ssm_output_fp16.md
# ssm_output_fp16

Reads the updated SSM state produced by the state-update stage and forms the per-head output y[b][h][p] = Σₙ h[b][h][p][n]·C[b][n] + D[h]·x[b][h][p] in FP16. It sits directly downstream of the h_next state buffer in the Mamba-2 SSM datapath. It uses one shared `fp16_mult_wrapper` and one shared `fp16_add_wrapper`. A fixed, bit-reproducible accumulation order is used so results match the golden model.

## Interface
Parameters:
- B, 1: batch size
- H, 4: heads
- P, 4: head dimension
- N, 4: state dimension (≥1)
- DW, 16: FP16 word width
- M_LAT, 6: multiplier latency, valid_in→valid_out, cycles
- A_LAT, 11: adder latency, valid_in→valid_out, cycles

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  single-cycle request to compute all outputs
- h_flat  in  B*H*P*N*DW  state; element g = [b*H*P*N+h*P*N+p*N+n] at bits [(g+1)*DW-1 -: DW]
- C_flat  in  B*N*DW  C[b][n], index b*N+n
- D_flat  in  H*DW  D[h], index h
- x_flat  in  B*H*P*DW  x[b][h][p], index b*H*P+h*P+p
- y_flat  out  B*H*P*DW  y[b][h][p], same indexing as x; registered
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last y element is written

## Operation
- FSM states: IDLE, MUL, ACC, WB, DONE.
- IDLE:
  - Accepts start; clears indices b=h=p=0 and goes to MUL.
  - start while busy is ignored.
- Element loop order: p innermost, then h, then b.
- MUL: issues N+1 multiplies on consecutive cycles, one per cycle with mult valid_in=1:
  - k=0: D[h]·x[b][h][p].
  - k=1..N: h[b][h][p][k-1]·C[b][k-1].
- Product buffer: product k is captured into buffer entry k when mult valid_out fires. Entries are counted in arrival order.
- ACC: serial chain with fixed order.
  - acc = prod0 + prod1.
  - Then acc = acc + prod(k) for k=2..N.
  - Adder inputs are registered. Add k issues (valid_in=1) the cycle after add k-1 valid_out. Add 1 issues the cycle after prod1 is captured.
  - No reassociation and no tree reduction.
- N=1 case: a single add, prod0+prod1.
- WB: writes acc into y[b][h][p] and advances indices.
  - After the last element, go to DONE; otherwise go to MUL.
- DONE: done=1 for one cycle, then IDLE. busy is low in IDLE.
- Input stability: inputs must be held stable from start until done; the block does not snapshot them.
- y holds its last values after done until the next run overwrites each element in WB.
- Rounding/NaN/Inf/subnormal behaviour comes entirely from the wrappers; the block adds no arithmetic of its own.

## Timing
- Reset values: y_flat=0, done=0, busy=0, state=IDLE; mult/add valid_in=0.
- Reset mid-run: abort at once, return to all reset values, and discard in-flight wrapper outputs.
  - After rst_n deasserts, wrapper valid_out pulses still in flight are ignored until the next start, because buffer and acc capture is gated by state.
- Cycle numbering: start is sampled high at cycle s. Element e's MUL begins at cycle s+1+e·T, where T = M_LAT + 3 + N·(A_LAT+1).
  - Within an element (cycle 0 = first MUL):
    - mult k issues at cycle k.
    - Last add valid_out is at M_LAT + 1 + N·(A_LAT+1).
    - WB is the next cycle.
    - The next element's MUL begins the cycle after WB.
- done is high exactly at cycle s+1+B·H·P·T.
- busy is high from s+1 through the done cycle −1.
- start asserted on the same cycle as done: ignored.
- start asserted in IDLE on the cycle after done: accepted.

## Test plan
- Reset check: hold rst_n=0, drive random inputs → y_flat=0, done=0, busy=0. Release and idle 100 cycles → done never pulses.
- Unit values, defaults: h=1.0 (0x3C00), C=1.0, D=0.5 (0x3800), x=2.0 (0x4000) → every y=0x4500 (5.0). done exactly at s+1+16·57 = s+913.
- Zero state: h=0, C=random, D[h]=h+1, x=1.0 → y[b][h][p]=D[h]. Checks the order-0 term alone.
- Order and sign, N=4: h[..][n]={1.0,−1.0,2048.0,1.0}, C=1.0, D=0, x=0 → y matches the serial left-to-right FP16 golden model, 0x6800. Checks the no-reassociation rounding of 2048+1.
- Reset mid-run: assert rst_n=0 at cycle s+200, release, then start with unit values → y all 0x4500. No stale writes, and done timing is identical to the unit-value scenario.
- Start handling: pulse start while busy at s+10 → ignored, one done only. Start on the cycle after done → second run, done at the same offset.
